// File: rtl/pcs_tx_pkg.sv
// Shared constants for the 1000BASE-X PCS transmit path: xmit modes,
// special octets, FSM state encoding and a small popcount helper.
package pcs_tx_pkg;

  localparam logic [2:0] XMIT_CONFIG = 3'b001;
  localparam logic [2:0] XMIT_IDLE   = 3'b010;
  localparam logic [2:0] XMIT_DATA   = 3'b100;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;

  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;
  localparam logic [7:0] D0_0  = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE_OS,
    ST_CONFIG_OS,
    ST_START,
    ST_DATA,
    ST_END_T,
    ST_END_R,
    ST_END_R2
  } tx_state_e;

  function automatic logic [2:0] ones_count(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/pcs_tx_if.sv
// GMII-side transmit bundle. TX_EN qualifies TXD every cycle; there is no
// back-pressure, the PCS consumes one octet per GTX_CLK whether or not it is used.
interface pcs_tx_if;
  import pcs_tx_pkg::*;

  logic        TX_EN;
  logic        TX_ER;
  logic [7:0]  TXD;
  logic        receiving;
  logic [2:0]  xmit;
  logic [9:0]  tx_code_group;
  logic        transmitting;
  logic        COL;
  tx_state_e   state;

  modport master (
    output TX_EN, TX_ER, TXD, receiving, xmit,
    input  tx_code_group, transmitting, COL, state
  );

  modport slave (
    input  TX_EN, TX_ER, TXD, receiving, xmit,
    output tx_code_group, transmitting, COL, state
  );
endinterface

// File: rtl/encoder_8b10b.sv
// Combinational 8b/10b encoder: 5b/6b then 3b/4b, with running disparity
// carried between the sub-blocks. Output order is abcdei fghj, a in bit 9.
module encoder_8b10b
  import pcs_tx_pkg::*;
(
  input  logic [7:0] octet,
  input  logic       is_k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out
);

  logic [4:0] w_x;
  logic [2:0] w_y;
  logic [5:0] w_c6;
  logic [5:0] w_s6;
  logic [3:0] w_c4;
  logic [3:0] w_s4;
  logic       w_unbal6;
  logic       w_unbal4;
  logic       w_rd_mid;
  logic       w_a7;

  assign w_x = octet[4:0];
  assign w_y = octet[7:5];

  always_comb begin
    // 6b table held in its RD- form; the RD+ form is the complement.
    case (w_x)
      5'd0:  w_c6 = 6'b100111;  5'd1:  w_c6 = 6'b011101;
      5'd2:  w_c6 = 6'b101101;  5'd3:  w_c6 = 6'b110001;
      5'd4:  w_c6 = 6'b110101;  5'd5:  w_c6 = 6'b101001;
      5'd6:  w_c6 = 6'b011001;  5'd7:  w_c6 = 6'b111000;
      5'd8:  w_c6 = 6'b111001;  5'd9:  w_c6 = 6'b100101;
      5'd10: w_c6 = 6'b010101;  5'd11: w_c6 = 6'b110100;
      5'd12: w_c6 = 6'b001101;  5'd13: w_c6 = 6'b101100;
      5'd14: w_c6 = 6'b011100;  5'd15: w_c6 = 6'b010111;
      5'd16: w_c6 = 6'b011011;  5'd17: w_c6 = 6'b100011;
      5'd18: w_c6 = 6'b010011;  5'd19: w_c6 = 6'b110010;
      5'd20: w_c6 = 6'b001011;  5'd21: w_c6 = 6'b101010;
      5'd22: w_c6 = 6'b011010;  5'd23: w_c6 = 6'b111010;
      5'd24: w_c6 = 6'b110011;  5'd25: w_c6 = 6'b100110;
      5'd26: w_c6 = 6'b010110;  5'd27: w_c6 = 6'b110110;
      5'd28: w_c6 = 6'b001110;  5'd29: w_c6 = 6'b101110;
      5'd30: w_c6 = 6'b011110;  default: w_c6 = 6'b101011;
    endcase
    if (is_k && w_x == 5'd28) w_c6 = 6'b001111;

    w_unbal6 = (ones_count(w_c6) != 3'd3);
    w_s6     = (rd_in && (w_unbal6 || w_c6 == 6'b111000)) ? ~w_c6 : w_c6;
    w_rd_mid = rd_in ^ w_unbal6;

    // Alternate x.7 avoids a run of five equal bits across the sub-block seam.
    w_a7 = is_k
         | (~w_rd_mid & (w_x == 5'd17 || w_x == 5'd18 || w_x == 5'd20))
         | ( w_rd_mid & (w_x == 5'd11 || w_x == 5'd13 || w_x == 5'd14));

    case (w_y)
      3'd0:    w_c4 = 4'b1011;
      3'd1:    w_c4 = is_k ? 4'b0110 : 4'b1001;
      3'd2:    w_c4 = is_k ? 4'b1010 : 4'b0101;
      3'd3:    w_c4 = 4'b1100;
      3'd4:    w_c4 = 4'b1101;
      3'd5:    w_c4 = is_k ? 4'b0101 : 4'b1010;
      3'd6:    w_c4 = is_k ? 4'b1001 : 4'b0110;
      default: w_c4 = w_a7 ? 4'b0111 : 4'b1110;
    endcase

    w_unbal4 = (ones_count({2'b00, w_c4}) != 3'd2);
    w_s4     = (w_rd_mid && (is_k || w_unbal4 || w_c4 == 4'b1100)) ? ~w_c4 : w_c4;

    code   = {w_s6, w_s4};
    rd_out = w_rd_mid ^ w_unbal4;
  end

endmodule

// File: rtl/pcs_transmit.sv
// 1000BASE-X PCS transmit: ordered-set generation, packet framing /S/../T/R/
// and 8b/10b encoding with running disparity. All outputs registered.
module pcs_transmit
  import pcs_tx_pkg::*;
(
  input  logic     GTX_CLK,
  input  logic     mr_main_reset,
  pcs_tx_if.slave  gmii
);

  tx_state_e  r_state;
  logic       r_even;
  logic       r_rd;
  logic [1:0] r_cfg_pos;
  logic       r_cfg_c2;
  logic [9:0] r_code;
  logic       r_transmitting;
  logic       r_col;

  tx_state_e  w_next_state;
  logic [7:0] w_octet;
  logic       w_is_k;
  logic       w_boundary;
  logic [1:0] w_next_cfg_pos;
  logic       w_next_cfg_c2;
  logic [9:0] w_code;
  logic       w_rd_next;
  logic       w_next_tx;

  encoder_8b10b u_enc (
    .octet  (w_octet),
    .is_k   (w_is_k),
    .rd_in  (r_rd),
    .code   (w_code),
    .rd_out (w_rd_next)
  );

  always_ff @(posedge GTX_CLK) begin
    if (mr_main_reset) begin
      r_state        <= ST_IDLE_OS;
      r_even         <= 1'b1;
      r_rd           <= 1'b0;
      r_cfg_pos      <= 2'd0;
      r_cfg_c2       <= 1'b0;
      r_code         <= 10'b0;
      r_transmitting <= 1'b0;
      r_col          <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_even         <= ~r_even;
      r_rd           <= w_rd_next;
      r_cfg_pos      <= w_next_cfg_pos;
      r_cfg_c2       <= w_next_cfg_c2;
      r_code         <= w_code;
      r_transmitting <= w_next_tx;
      r_col          <= w_next_tx & gmii.receiving;
    end
  end

  // r_state names the code group most recently emitted; r_even is the parity
  // of the slot being produced this cycle.
  always_comb begin
    w_next_state   = r_state;
    w_octet        = K28_5;
    w_is_k         = 1'b1;
    w_boundary     = 1'b0;
    w_next_cfg_pos = r_cfg_pos;
    w_next_cfg_c2  = r_cfg_c2;

    case (r_state)
      ST_START, ST_DATA: begin
        if (gmii.TX_EN) begin
          w_next_state = ST_DATA;
          w_is_k       = gmii.TX_ER;
          w_octet      = gmii.TX_ER ? K30_7 : gmii.TXD;
        end else begin
          w_next_state = ST_END_T;
          w_octet      = K29_7;
        end
      end
      ST_END_T: begin
        w_next_state = ST_END_R;
        w_octet      = K23_7;
      end
      ST_END_R: begin
        if (r_even) begin
          w_boundary = 1'b1;
        end else begin
          w_next_state = ST_END_R2;
          w_octet      = K23_7;
        end
      end
      ST_END_R2: w_boundary = 1'b1;
      ST_CONFIG_OS: begin
        if (r_even && r_cfg_pos == 2'd0) begin
          w_boundary = 1'b1;
        end else begin
          w_is_k         = 1'b0;
          w_next_cfg_pos = r_cfg_pos + 2'd1;
          w_octet        = (r_cfg_pos == 2'd1) ? (r_cfg_c2 ? D2_2 : D21_5) : D0_0;
        end
      end
      default: begin
        if (r_even) begin
          w_boundary = 1'b1;
        end else begin
          // r_rd is already past the K28.5, so negative here means it was positive before.
          w_is_k  = 1'b0;
          w_octet = r_rd ? D16_2 : D5_6;
        end
      end
    endcase

    // A packet that just ended must see a full idle set before the next /S/.
    if (w_boundary) begin
      if (gmii.xmit == XMIT_DATA && gmii.TX_EN &&
          !(r_state inside {ST_END_R, ST_END_R2})) begin
        w_next_state = ST_START;
        w_octet      = K27_7;
      end else if (gmii.xmit == XMIT_CONFIG) begin
        w_next_state   = ST_CONFIG_OS;
        w_next_cfg_pos = 2'd1;
        w_next_cfg_c2  = (r_state == ST_CONFIG_OS) ? ~r_cfg_c2 : 1'b0;
      end else begin
        w_next_state = ST_IDLE_OS;
      end
    end
  end

  assign w_next_tx = w_next_state inside {ST_START, ST_DATA, ST_END_T, ST_END_R, ST_END_R2};

  assign gmii.tx_code_group = r_code;
  assign gmii.transmitting  = r_transmitting;
  assign gmii.COL           = r_col;
  assign gmii.state         = r_state;

endmodule

// File: tb/tb_pcs_transmit.sv
// Directed bench for pcs_transmit: idle, packet framing, odd-slot start,
// error propagation, collision, configuration sets and mid-packet reset.
module tb_pcs_transmit;
  import pcs_tx_pkg::*;

  localparam logic [2:0] XC = 3'b001;
  localparam logic [2:0] XI = 3'b010;
  localparam logic [2:0] XD = 3'b100;

  localparam logic [9:0] K28_5_N = 10'b0011111010, K28_5_P = 10'b1100000101;
  localparam logic [9:0] K27_7_N = 10'b1101101000;
  localparam logic [9:0] K29_7_N = 10'b1011101000, K29_7_P = 10'b0100010111;
  localparam logic [9:0] K23_7_N = 10'b1110101000, K23_7_P = 10'b0001010111;
  localparam logic [9:0] K30_7_P = 10'b1000010111;
  localparam logic [9:0] D16_2_P = 10'b1001000101;
  localparam logic [9:0] D5_6_C  = 10'b1010010110;
  localparam logic [9:0] D21_2_C = 10'b1010100101;
  localparam logic [9:0] D21_6_C = 10'b1010100110;
  localparam logic [9:0] D21_5_C = 10'b1010101010;
  localparam logic [9:0] D2_2_N  = 10'b1011010101;
  localparam logic [9:0] D0_0_N  = 10'b1001110100, D0_0_P = 10'b0110001011;

  logic       clk;
  logic       rst;
  int         n_checks;
  int         n_errors;
  logic [9:0] exp_q[$];
  logic [9:0] exp_v;

  pcs_tx_if gmii ();

  pcs_transmit dut (
    .GTX_CLK       (clk),
    .mr_main_reset (rst),
    .gmii          (gmii.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] x, input logic en, input logic er,
                       input logic [7:0] d, input logic rcv);
    gmii.xmit      = x;
    gmii.TX_EN     = en;
    gmii.TX_ER     = er;
    gmii.TXD       = d;
    gmii.receiving = rcv;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [2:0] x, input logic en, input logic er,
                     input logic [7:0] d, input logic rcv,
                     input logic [9:0] e_code, input logic e_tx, input logic e_col);
    drive(x, en, er, d, rcv);
    check_eq({tag, ".cg"}, gmii.tx_code_group, e_code);
    check_eq({tag, ".tx"}, {9'b0, gmii.transmitting}, {9'b0, e_tx});
    check_eq({tag, ".col"}, {9'b0, gmii.COL}, {9'b0, e_col});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive(XI, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc("rst", XD, 1'b1, 1'b0, 8'h55, 1'b1, 10'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // idle ordered sets from RD-
    cyc("t1_0", XI, 1'b0, 1'b0, 8'h00, 1'b0, K28_5_N, 1'b0, 1'b0);
    cyc("t1_1", XI, 1'b0, 1'b0, 8'h00, 1'b0, D16_2_P, 1'b0, 1'b0);
    cyc("t1_2", XI, 1'b0, 1'b0, 8'h00, 1'b0, K28_5_N, 1'b0, 1'b0);
    cyc("t1_3", XI, 1'b0, 1'b0, 8'h00, 1'b0, D16_2_P, 1'b0, 1'b0);

    // packet starting on an even slot, /R/ lands odd so idle resumes
    cyc("t2_s",  XD, 1'b1, 1'b0, 8'h55, 1'b0, K27_7_N, 1'b1, 1'b0);
    cyc("t2_d0", XD, 1'b1, 1'b0, 8'h55, 1'b0, D21_2_C, 1'b1, 1'b0);
    cyc("t2_d1", XD, 1'b1, 1'b0, 8'h55, 1'b0, D21_2_C, 1'b1, 1'b0);
    cyc("t2_d2", XD, 1'b1, 1'b0, 8'hD5, 1'b0, D21_6_C, 1'b1, 1'b0);
    cyc("t2_t",  XD, 1'b0, 1'b0, 8'h00, 1'b0, K29_7_N, 1'b1, 1'b0);
    cyc("t2_r",  XD, 1'b0, 1'b0, 8'h00, 1'b0, K23_7_N, 1'b1, 1'b0);
    cyc("t2_i0", XD, 1'b0, 1'b0, 8'h00, 1'b0, K28_5_N, 1'b0, 1'b0);
    cyc("t2_i1", XD, 1'b0, 1'b0, 8'h00, 1'b0, D16_2_P, 1'b0, 1'b0);

    // TX_EN rises on an odd slot
    cyc("t3_i0",  XD, 1'b0, 1'b0, 8'h00, 1'b0, K28_5_N, 1'b0, 1'b0);
    cyc("t3_odd", XD, 1'b1, 1'b0, 8'h11, 1'b0, D16_2_P, 1'b0, 1'b0);
    cyc("t3_s",   XD, 1'b1, 1'b0, 8'h22, 1'b0, K27_7_N, 1'b1, 1'b0);

    // D2.2 flips RD+, so the /V/ must be the RD+ form; then /T/R/R and an immediate re-request
    cyc("t4_d0", XD, 1'b1, 1'b0, 8'h42, 1'b0, D2_2_N,  1'b1, 1'b0);
    cyc("t4_v",  XD, 1'b1, 1'b1, 8'h55, 1'b0, K30_7_P, 1'b1, 1'b0);
    cyc("t4_d2", XD, 1'b1, 1'b0, 8'h55, 1'b0, D21_2_C, 1'b1, 1'b0);
    cyc("t4_d3", XD, 1'b1, 1'b0, 8'h55, 1'b0, D21_2_C, 1'b1, 1'b0);
    cyc("t4_t",  XD, 1'b0, 1'b1, 8'h00, 1'b0, K29_7_P, 1'b1, 1'b0);
    cyc("t4_r",  XD, 1'b1, 1'b0, 8'h00, 1'b0, K23_7_P, 1'b1, 1'b0);
    cyc("t4_r2", XD, 1'b1, 1'b0, 8'h00, 1'b0, K23_7_P, 1'b1, 1'b0);
    cyc("t4_i0", XD, 1'b1, 1'b0, 8'h00, 1'b1, K28_5_P, 1'b0, 1'b0);
    cyc("t4_i1", XD, 1'b1, 1'b0, 8'h00, 1'b1, D5_6_C,  1'b0, 1'b0);

    // collision while transmitting with receiving held high
    cyc("t5_s",  XD, 1'b1, 1'b0, 8'h55, 1'b1, K27_7_N, 1'b1, 1'b1);
    cyc("t5_t",  XD, 1'b0, 1'b0, 8'h00, 1'b1, K29_7_N, 1'b1, 1'b1);
    cyc("t5_r",  XD, 1'b0, 1'b0, 8'h00, 1'b1, K23_7_N, 1'b1, 1'b1);
    cyc("t5_r2", XD, 1'b0, 1'b0, 8'h00, 1'b1, K23_7_N, 1'b1, 1'b1);
    cyc("t5_i0", XD, 1'b0, 1'b0, 8'h00, 1'b1, K28_5_N, 1'b0, 1'b0);
    cyc("t5_i1", XD, 1'b0, 1'b0, 8'h00, 1'b1, D16_2_P, 1'b0, 1'b0);

    // configuration: /C1/ /C2/ /C1/..., then a mode change that must wait for the set to finish
    exp_q.push_back(K28_5_N); exp_q.push_back(D21_5_C);
    exp_q.push_back(D0_0_P);  exp_q.push_back(D0_0_P);
    exp_q.push_back(K28_5_P); exp_q.push_back(D2_2_N);
    exp_q.push_back(D0_0_P);  exp_q.push_back(D0_0_P);
    exp_q.push_back(K28_5_P); exp_q.push_back(D21_5_C);
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      cyc("t6_cfg", XC, 1'b0, 1'b0, 8'h00, 1'b0, exp_v, 1'b0, 1'b0);
    end
    cyc("t6_c0", XI, 1'b0, 1'b0, 8'h00, 1'b0, D0_0_N,  1'b0, 1'b0);
    cyc("t6_c1", XI, 1'b0, 1'b0, 8'h00, 1'b0, D0_0_N,  1'b0, 1'b0);
    cyc("t6_i0", XI, 1'b0, 1'b0, 8'h00, 1'b0, K28_5_N, 1'b0, 1'b0);
    cyc("t6_i1", XI, 1'b0, 1'b0, 8'h00, 1'b0, D16_2_P, 1'b0, 1'b0);

    // reset in the middle of a packet
    cyc("t7_s", XD, 1'b1, 1'b0, 8'h55, 1'b1, K27_7_N, 1'b1, 1'b1);
    cyc("t7_d", XD, 1'b1, 1'b0, 8'h55, 1'b1, D21_2_C, 1'b1, 1'b1);
    rst = 1'b1;
    cyc("t7_rst", XD, 1'b1, 1'b0, 8'h55, 1'b1, 10'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("t7_i0", XI, 1'b0, 1'b0, 8'h00, 1'b0, K28_5_N, 1'b0, 1'b0);
    cyc("t7_i1", XI, 1'b0, 1'b0, 8'h00, 1'b0, D16_2_P, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pcs_transmit.md
# pcs_transmit

Gigabit (1000BASE-X) PCS transmit block: converts the GMII transmit stream (TXD, TX_EN, TX_ER) into 10-bit 8b/10b code groups with running disparity. It sends idle or configuration ordered sets between packets and frames packets with /S/ … /T/R/. It sits between the MAC-side GMII and the serializer, and reports `transmitting` and `COL` back to the GMII/receive side.

## Interface
- No parameters.
- `GTX_CLK` in 1: sole clock; all logic on the rising edge.
- `mr_main_reset` in 1: synchronous, active-high reset.
- `TX_EN` in 1: GMII transmit enable.
- `TX_ER` in 1: GMII transmit error.
- `TXD` in 8: GMII transmit octet.
- `receiving` in 1: receive path is inside a packet.
- `xmit` in 3: one-hot mode.
  - 3'b001 CONFIGURATION
  - 3'b010 IDLE
  - 3'b100 DATA
  - Any other value is treated as IDLE.
- `tx_code_group` out 10: encoded code group.
  - Bit 9 is `a` and bit 0 is `j`, i.e. in abcdei fghj order.
- `transmitting` out 1: high while a packet is being sent.
- `COL` out 1: collision indication, `transmitting & receiving`.

## Operation
- **State:**
  - Running disparity `rd`: 0 is negative, 1 is positive.
  - Slot parity `tx_even`.
  - FSM with states IDLE_OS, CONFIG_OS, START, DATA, END_T, END_R, END_R2.
- **Alignment:** every ordered set begins on an even slot. `tx_even` toggles every cycle.
- **IDLE_OS** (`xmit` is IDLE, or DATA with TX_EN=0):
  - Even slot: K28.5.
  - Odd slot: /I1/ D5.6 if `rd` was positive before that K28.5; otherwise /I2/ D16.2.
- **CONFIG_OS** (`xmit` = CONFIGURATION): alternates /C1/ = K28.5 D21.5 D0.0 D0.0 and /C2/ = K28.5 D2.2 D0.0 D0.0. The config register is fixed at 0.
- **Mode changes:** `xmit` is sampled only on even slots outside a packet. The current ordered set always completes.
- **START:** in DATA mode, TX_EN=1 sampled on an even slot emits /S/ (K27.7) in place of that octet and sets `transmitting`.
  - If TX_EN rises on an odd slot, the idle set completes first.
  - /S/ then replaces the next octet; the skipped octet is discarded.
- **DATA:** each cycle with TX_EN=1:
  - TX_ER=0: encode TXD as Dx.y.
  - TX_ER=1: emit /V/ (K30.7).
- **End of packet:** the first cycle with TX_EN=0 emits /T/ (K29.7), then /R/ (K23.7).
  - If the slot after that /R/ is odd, a second /R/ follows (END_R2).
  - Idle then resumes on an even slot.
  - `transmitting` clears after the last /R/.
- TX_ER with TX_EN=0 is ignored; carrier extension is not supported.
- **Disparity:** `rd` updates after every code group per 8b/10b rules, using the sub-block disparity of 6b then 4b. Neutral groups leave `rd` unchanged.
- **Required code values** (RD− / RD+):
  - K28.5: 0011111010 / 1100000101
  - K27.7: 1101101000 / 0010010111
  - K29.7: 1011101000 / 0100010111
  - K23.7: 1110101000 / 0001010111
  - K30.7: 0111101000 / 1000010111
  - D16.2: 0110110101 / 1001000101
  - D5.6: 1010010110 (both)

## Timing
- All outputs are registered.
- Latency is 1 cycle: inputs sampled at edge k produce `tx_code_group` valid after edge k.
- `COL` is registered from `transmitting` (next value) and `receiving`, so it has the same 1-cycle latency.
- **Reset** (synchronous, `mr_main_reset`=1 at an edge):
  - `tx_code_group` = 10'b0, `transmitting` = 0, `COL` = 0.
  - `rd` = negative, `tx_even` = 1 (next slot even), FSM = IDLE_OS.
- Reset mid-packet aborts immediately, with no /T/R/. The first code group after reset release is K28.5 RD− on an even slot.
- TX_EN falling and rising in back-to-back cycles: the /T/R/(R) sequence is mandatory, and a new /S/ may only follow at least one full idle ordered set.

## Structure
- **Package `pcs_tx_pkg`:**
  - `xmit` encodings.
  - K-code octets: K28.5 = 8'hBC, K27.7 = 8'hFB, K29.7 = 8'hFD, K23.7 = 8'hF7, K30.7 = 8'hFE.
  - D octets: D5.6 = 8'hC5, D16.2 = 8'h50, D21.5 = 8'hB5, D2.2 = 8'h42, D0.0 = 8'h00.
  - FSM state enum.
- **Sub-module `encoder_8b10b`:**
  - Combinational.
  - Inputs: octet[7:0], `is_k`, `rd_in`.
  - Outputs: code[9:0], `rd_out`.
  - Implements the full 5b/6b and 3b/4b tables, including the D.x.7 alternate (A7) rule.
- The top level holds the FSM, `tx_even`, `rd` and the output registers.

## Test plan
1. Reset, then `xmit` = IDLE for 4 cycles → 0011111010, 1001000101, 0011111010, 1001000101; `transmitting` = 0.
2. `xmit` = DATA, TX_EN=1 on an even slot with TXD 55,55,D5, TX_EN=0 → /S/ K27.7, D21.2, D21.2, D21.6, /T/, /R/, then R or K28.5 per parity. `transmitting` is 1 from /S/ through the last /R/.
3. TX_EN rises on an odd slot → the idle set completes (D16.2), then /S/ replaces the second octet.
4. TX_ER=1 during the second data octet → that slot outputs K30.7 in the correct-disparity form.
5. `receiving`=1 while transmitting → `COL`=1 exactly while `transmitting`=1; `COL`=0 when `receiving`=1 and idle.
6. `xmit` = CONFIGURATION → K28.5, D21.5, D0.0, D0.0, K28.5, D2.2, D0.0, D0.0 with correct `rd`; assert `mr_main_reset` mid-packet → all outputs 0 at the next edge.
